// File: rtl/mux_4to1.sv
// Registered 4:1 selector. Select is {S1,S2}; Y loads the selected input on
// a rising clk edge when en=1, and clears asynchronously on rst_n low.

module mux_4to1_lane (
    input  logic [3:0] x,
    input  logic [1:0] sel,
    output logic       d
);
    // An unresolved select yields X in simulation instead of falling back to X0.
    always_comb begin
        d = 1'bx;
        case (sel)
            2'b00:   d = x[0];
            2'b01:   d = x[1];
            2'b10:   d = x[2];
            2'b11:   d = x[3];
            default: d = 1'bx;
        endcase
    end
endmodule

module mux_4to1 #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] X0,
    input  logic [WIDTH-1:0] X1,
    input  logic [WIDTH-1:0] X2,
    input  logic [WIDTH-1:0] X3,
    input  logic             S1,
    input  logic             S2,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en
);
    logic [1:0]       sel;
    logic [WIDTH-1:0] d;

    assign sel = {S1, S2};

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        mux_4to1_lane u_lane (
            .x   ({X3[i], X2[i], X1[i], X0[i]}),
            .sel (sel),
            .d   (d[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  Y <= RESET_VALUE;
        else if (en) Y <= d;
    end
endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: WIDTH=1 and WIDTH=8 instances driven from
// a decode table, directed corner sequences and a random run against a model.

module tb_mux_4to1;
    logic       clk = 1'b0;
    logic       rst_n, en, s1, s2;
    logic       a0, a1, a2, a3, y1;
    logic [7:0] b0, b1, b2, b3, y8;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    mux_4to1 #(.WIDTH(1)) dut1 (
        .Y(y1), .X0(a0), .X1(a1), .X2(a2), .X3(a3), .S1(s1), .S2(s2),
        .clk(clk), .rst_n(rst_n), .en(en)
    );

    mux_4to1 #(.WIDTH(8)) dut8 (
        .Y(y8), .X0(b0), .X1(b1), .X2(b2), .X3(b3), .S1(s1), .S2(s2),
        .clk(clk), .rst_n(rst_n), .en(en)
    );

    typedef struct {
        logic [1:0] sel;
        logic [3:0] x;      // x[k] drives Xk
        logic       exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic [1:0] sel, input logic [3:0] x);
        {s1, s2} = sel;
        {a3, a2, a1, a0} = x;
    endtask

    initial begin
        logic [7:0] xs[4];
        logic [7:0] m8;
        logic       m1;
        logic [1:0] sel;
        vec_t       v;

        // directed single-high cases with literal expectations
        v.sel = 2'b00; v.x = 4'b0001; v.exp = 1'b1; tbl.push_back(v);
        v.sel = 2'b01; v.x = 4'b0001; v.exp = 1'b0; tbl.push_back(v);
        v.sel = 2'b10; v.x = 4'b0001; v.exp = 1'b0; tbl.push_back(v);
        v.sel = 2'b11; v.x = 4'b0001; v.exp = 1'b0; tbl.push_back(v);
        v.sel = 2'b01; v.x = 4'b0010; v.exp = 1'b1; tbl.push_back(v);
        v.sel = 2'b10; v.x = 4'b0100; v.exp = 1'b1; tbl.push_back(v);
        v.sel = 2'b11; v.x = 4'b1000; v.exp = 1'b1; tbl.push_back(v);
        v.sel = 2'b00; v.x = 4'b1110; v.exp = 1'b0; tbl.push_back(v);
        // all 64 combinations: output is the input bit indexed by the select
        for (int k = 0; k < 64; k++) begin
            v.sel = k[5:4];
            v.x   = k[3:0];
            v.exp = v.x[v.sel];
            tbl.push_back(v);
        end

        // reset held with clocks running and everything high
        rst_n = 1'b0; en = 1'b1; drive1(2'b00, 4'b1111);
        {b0, b1, b2, b3} = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        #2;
        chk("reset_async_y1", {7'b0, y1}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_hold_y1", {7'b0, y1}, 8'h00);
            chk("reset_hold_y8", y8, 8'h00);
        end
        rst_n = 1'b1;
        tick();
        chk("first_load_y1", {7'b0, y1}, 8'h01);
        chk("first_load_y8", y8, 8'hFF);

        foreach (tbl[i]) begin
            drive1(tbl[i].sel, tbl[i].x);
            tick();
            chk($sformatf("table[%0d]", i), {7'b0, y1}, {7'b0, tbl[i].exp});
        end

        // enable hold
        drive1(2'b10, 4'b0100); tick();
        chk("hold_load", {7'b0, y1}, 8'h01);
        en = 1'b0; drive1(2'b00, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_en0", {7'b0, y1}, 8'h01);
        end
        en = 1'b1; tick();
        chk("hold_release", {7'b0, y1}, 8'h00);

        // async reset between edges
        drive1(2'b11, 4'b1000); tick();
        chk("mid_load", {7'b0, y1}, 8'h01);
        #2 rst_n = 1'b0;
        #1 chk("mid_reset_y1", {7'b0, y1}, 8'h00);
        #1 rst_n = 1'b1;
        tick();
        chk("mid_reload", {7'b0, y1}, 8'h01);

        // one-cycle latency
        drive1(2'b00, 4'b1000); tick();
        chk("lat_base", {7'b0, y1}, 8'h00);
        drive1(2'b11, 4'b1000);
        #3 chk("lat_before_edge", {7'b0, y1}, 8'h00);
        tick();
        chk("lat_after_edge", {7'b0, y1}, 8'h01);

        // 8-bit sweep
        {b0, b1, b2, b3} = {8'hA5, 8'h3C, 8'hFF, 8'h00};
        {s1, s2} = 2'b00; tick(); chk("w8_sel00", y8, 8'hA5);
        {s1, s2} = 2'b01; tick(); chk("w8_sel01", y8, 8'h3C);
        {s1, s2} = 2'b10; tick(); chk("w8_sel10", y8, 8'hFF);
        {s1, s2} = 2'b11; tick(); chk("w8_sel11", y8, 8'h00);

        // random run against a register-of-indexed-array model
        m8 = y8; m1 = y1;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++) xs[k] = 8'($urandom);
            sel = 2'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            {b0, b1, b2, b3} = {xs[0], xs[1], xs[2], xs[3]};
            {a0, a1, a2, a3} = {xs[0][0], xs[1][0], xs[2][0], xs[3][0]};
            {s1, s2} = sel;
            tick();
            if (en) begin
                m8 = xs[sel];
                m1 = xs[sel][0];
            end
            chk("rand_y8", y8, m8);
            chk("rand_y1", {7'b0, y1}, {7'b0, m1});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mux_4to1.md
Name: mux_4to1

Overview:
- Four-input, one-output selector with a 2-bit select split across two single-bit inputs (S1 = MSB, S2 = LSB).
- Output Y is registered on the clock, with an asynchronous active-low reset.
- Data width is parameterised. The default 1-bit configuration serves as the basic steering primitive in the combinational-logic exercises of the design.

Parameters:
- WIDTH, 1, bit width of each data input X0..X3 and of output Y.
- RESET_VALUE, 0 (WIDTH bits), value loaded into Y on reset.

Ports:
- clk  input  1  rising-edge clock; Y updates only on this edge.
- rst_n  input  1  asynchronous active-low reset; clears Y to RESET_VALUE immediately on assertion.
- en  input  1  capture enable; Y loads the selected input only when en=1 at a rising clk edge, otherwise holds.
- Y  output  WIDTH  registered selected data.
- X0  input  WIDTH  data input, selected when {S1,S2}=00.
- X1  input  WIDTH  data input, selected when {S1,S2}=01.
- X2  input  WIDTH  data input, selected when {S1,S2}=10.
- X3  input  WIDTH  data input, selected when {S1,S2}=11.
- S1  input  1  select MSB.
- S2  input  1  select LSB.

Behaviour:
- Positional port order on instantiation is fixed: Y, X0, X1, X2, X3, S1, S2, followed by clk, rst_n, en. Named connection is preferred for the last three.
- Select decode is sel = {S1,S2}:
  - 00 -> X0
  - 01 -> X1
  - 10 -> X2
  - 11 -> X3
- Decode is purely combinational into the D input of the Y register. There is no priority or one-hot logic.
- Latency is exactly 1 clock: a value selected before rising edge N appears on Y after edge N, if en=1 at edge N.
- en=0 at an edge: Y holds its previous value. Changes on X* or S* are not visible.
- Reset:
  - rst_n low forces Y=RESET_VALUE asynchronously, independent of clk, en, X*, S*.
  - Y holds RESET_VALUE while rst_n is low.
  - First load happens on the first rising edge with rst_n=1 and en=1.
- Reset asserted mid-operation: Y clears immediately. No pending capture survives.
- Reset release coincident with a rising edge: that edge does not load. The first load is the next edge.
- Simultaneous change of S1/S2 and X* before an edge: the edge captures the data selected by the settled select value.
- Unknown (X/Z) select in simulation: Y becomes X after the capturing edge. No silent default to X0. Synthesis treats all four codes as fully specified; no latch is inferred.
- Width rule: all data paths are exactly WIDTH bits. No extension or truncation.
- No internal state other than the Y register.

Test Plan:
- Reset: rst_n=0 with en=1, X0..X3=1, and clocks toggling -> Y=0 throughout. Release rst_n; on the first edge after release with {S1,S2}=00 -> Y=1.
- Exhaustive select, WIDTH=1, en=1:
  - X0..X3 = 1,0,0,0 with sel=00 -> Y=1.
  - Sel=01, 10, 11 -> Y=0 each, one edge after applying the select.
  - Repeat with each single input high; Y=1 only when sel matches that input.
  - All 64 combinations of {S1,S2,X0..X3} checked against the decode table.
- Enable hold: load Y=1 via X2 (sel=10), set en=0, then drive X2=0 and sel=00 with X0=0 for 3 edges -> Y stays 1. Set en=1 -> Y=0 on the next edge.
- Async reset mid-stream: Y=1 loaded; pulse rst_n low between clock edges -> Y=0 immediately, without waiting for an edge.
- Latency check: change sel from 00 to 11 (X0=0, X3=1) just after an edge -> Y still 0 until the next rising edge, then Y=1.
- WIDTH=8 instance: X0=8'hA5, X1=8'h3C, X2=8'hFF, X3=8'h00, sweep sel 00..11 -> Y = A5, 3C, FF, 00 on successive edges.
